// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding request FSM feeding a DEPTH-entry
// prefetch FIFO, drained into a registered IF/ID output stage.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        valid
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetchStateT;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetchEntryT;

    fetchStateT  state;
    logic [31:0] fetchPC;
    fetchEntryT  fifo [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [AW:0]   count;
    logic push, pop, canIssue, notEmpty;

    assign notEmpty = (count != '0);
    assign canIssue = (count < (AW+1)'(DEPTH));
    // Only a live (non-dropped, non-redirected) response enters the buffer.
    assign push     = (state == WAIT) && imemAck && !branchTaken;
    assign pop      = !branchTaken && !freeze && notEmpty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetchPC  <= RESET_PC;
            imemReq  <= 1'b0;
            imemAddr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (branchTaken) begin
                        fetchPC <= branchAddr;
                    end else if (canIssue) begin
                        state    <= WAIT;
                        imemReq  <= 1'b1;
                        imemAddr <= fetchPC;
                    end
                end
                WAIT: begin
                    if (imemAck) begin
                        state   <= IDLE;
                        imemReq <= 1'b0;
                        fetchPC <= branchTaken ? branchAddr : fetchPC + 32'd4;
                    end else if (branchTaken) begin
                        state   <= DROP;
                        fetchPC <= branchAddr;
                    end
                end
                DROP: begin
                    // The stale response still has to be absorbed before reissuing.
                    if (branchTaken) fetchPC <= branchAddr;
                    if (imemAck) begin
                        state   <= IDLE;
                        imemReq <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    imemReq <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wrPtr] <= '{pc: imemAddr + 32'd4, ins: imemData};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (branchTaken) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Output stage reads the registered head, so a same-cycle push is not visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid       <= 1'b0;
            PC          <= '0;
            instruction <= '0;
        end else if (branchTaken) begin
            valid       <= 1'b0;
            PC          <= '0;
            instruction <= '0;
        end else if (!freeze) begin
            if (notEmpty) begin
                valid       <= 1'b1;
                PC          <= fifo[rdPtr].pc;
                instruction <= fifo[rdPtr].ins;
            end else begin
                valid       <= 1'b0;
                instruction <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a transaction-level model.
module tb_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk, rst, freeze, branchTaken, imemReq, imemAck, valid;
    logic [31:0] branchAddr, imemAddr, imemData, PC, instruction;

    logic rst2, req2, valid2;
    logic [31:0] addr2, pc2, ins2, data2;
    logic zero1, ack2;
    logic [31:0] zero32;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } entT;

    entT mq[$];
    bit mPending, mStale, mValid;
    logic [31:0] mReqAddr, mFetchPC, mPC, mIns;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(branchTaken),
        .branchAddr(branchAddr), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemAck(imemAck), .imemData(imemData), .PC(PC),
        .instruction(instruction), .valid(valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dutWrap (
        .clk(clk), .rst(rst2), .freeze(zero1), .branchTaken(zero1),
        .branchAddr(zero32), .imemReq(req2), .imemAddr(addr2),
        .imemAck(ack2), .imemData(data2), .PC(pc2),
        .instruction(ins2), .valid(valid2)
    );

    assign zero1  = 1'b0;
    assign zero32 = 32'h0;
    assign ack2   = req2;
    assign data2  = addr2 >> 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mReset();
        mq.delete();
        mPending = 0;
        mStale   = 0;
        mFetchPC = RPC;
        mReqAddr = RPC;
        mValid   = 0;
        mPC      = 0;
        mIns     = 0;
    endtask

    // Transaction view: one outstanding request, a queue of fetched words,
    // and an output slot fed from the queue as it stood before this edge.
    task automatic modelStep();
        int occ;
        entT e;
        occ = mq.size();
        if (branchTaken) begin
            mValid = 0; mPC = 0; mIns = 0;
        end else if (!freeze) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                mValid = 1; mPC = e.pc; mIns = e.ins;
            end else begin
                mValid = 0; mIns = 0;
            end
        end
        if (mPending) begin
            if (imemAck) begin
                if (!mStale && !branchTaken) begin
                    mq.push_back('{mReqAddr + 32'd4, imemData});
                    mFetchPC = mFetchPC + 32'd4;
                end
                mPending = 0;
            end else if (branchTaken) begin
                mStale = 1;
            end
        end else if (!branchTaken && occ < DEPTH) begin
            mPending = 1;
            mStale   = 0;
            mReqAddr = mFetchPC;
        end
        if (branchTaken) begin
            mFetchPC = branchAddr;
            mq.delete();
        end
    endtask

    task automatic compare();
        chk("valid", valid, mValid);
        chk("PC", PC, mPC);
        chk("instruction", instruction, mIns);
        chk("imemReq", imemReq, mPending);
        if (mPending) chk("imemAddr", imemAddr, mReqAddr);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) mReset(); else modelStep();
        @(negedge clk);
        compare();
    endtask

    task automatic driveMem(input int pct, input int spur, input bit idx);
        if (imemReq) imemAck = ($urandom_range(0, 99) < pct);
        else         imemAck = ($urandom_range(0, 99) < spur);
        imemData = idx ? (imemAddr >> 2) : $urandom;
    endtask

    task automatic waitReq();
        int n;
        n = 0;
        while (!imemReq && n < 20) begin
            imemAck = 0;
            tick();
            n++;
        end
        chk("waitReq", imemReq, 1);
    endtask

    task automatic waitValid();
        int n;
        n = 0;
        while (!valid && n < 30) begin
            driveMem(100, 0, 1);
            tick();
            n++;
        end
        chk("waitValid", valid, 1);
    endtask

    initial begin
        int k, n, m;
        bit frz, prevReq;
        logic [31:0] expA [4];
        logic [31:0] expP [3];

        rst = 0; rst2 = 0; freeze = 0; branchTaken = 0; branchAddr = 0;
        imemAck = 0; imemData = 0;
        mReset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        chk("rstAddr", imemAddr, RPC);
        rst = 1;

        // Zero-wait stream with a five-cycle freeze in the middle.
        k = 0;
        for (int c = 0; c < 40; c++) begin
            frz = (c >= 15 && c < 20);
            freeze = frz;
            driveMem(100, 0, 1);
            tick();
            if (!frz && valid) begin
                chk("seqPC", PC, 32'(4 * (k + 1)));
                chk("seqIns", instruction, 32'(k));
                k++;
            end
            if (c == 19) chk("freezeNoReq", imemReq, 0);
        end
        chk("seqEnough", 32'(k >= 10), 1);
        freeze = 0;

        // Redirect while waiting, late ack for the stale request.
        waitReq();
        branchTaken = 1; branchAddr = 32'h100; imemAck = 0;
        tick();
        branchTaken = 0;
        tick();
        tick();
        imemAck = 1; imemData = 32'hDEAD_BEEF;
        tick();
        waitValid();
        chk("br100PC", PC, 32'h104);
        chk("br100Ins", instruction, 32'h40);

        // Redirect coincident with the ack.
        waitReq();
        branchTaken = 1; branchAddr = 32'h200; imemAck = 1; imemData = imemAddr >> 2;
        tick();
        branchTaken = 0;
        waitValid();
        chk("br200PC", PC, 32'h204);
        chk("br200Ins", instruction, 32'h80);

        // Random traffic: stalls, redirects (some near the top of memory), spurious acks.
        for (int c = 0; c < 3000; c++) begin
            freeze      = ($urandom_range(0, 99) < 20);
            branchTaken = ($urandom_range(0, 99) < 5);
            branchAddr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                      : ($urandom & 32'hFFFF_FFFC);
            driveMem(50, 10, 0);
            tick();
        end
        freeze = 0; branchTaken = 0;

        // Asynchronous reset while a request is outstanding.
        n = 0;
        while (!(valid && imemReq) && n < 30) begin
            driveMem(100, 0, 1);
            tick();
            n++;
        end
        chk("preRstValid", valid, 1);
        chk("preRstReq", imemReq, 1);
        imemAck = 0;
        #2 rst = 0;
        #1;
        chk("asyncValid", valid, 0);
        chk("asyncPC", PC, 0);
        chk("asyncIns", instruction, 0);
        chk("asyncReq", imemReq, 0);
        chk("asyncAddr", imemAddr, RPC);
        mReset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) tick();
        rst = 1;
        imemAck = 1; imemData = 32'h1234_5678;
        tick();
        chk("relReq", imemReq, 1);
        chk("relAddr", imemAddr, RPC);
        waitValid();
        chk("relPC", PC, 32'h4);
        chk("relIns", instruction, 32'h0);

        // Address wrap on a second instance starting near the top of memory.
        expA = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        expP = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        n = 0; m = 0; prevReq = 0;
        rst2 = 1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (req2 && !prevReq && n < 4) begin
                chk("wrapAddr", addr2, expA[n]);
                n++;
            end
            if (valid2 && m < 3) begin
                chk("wrapPC", pc2, expP[m]);
                m++;
            end
            prevReq = req2;
        end
        chk("wrapReqCount", 32'(n), 4);
        chk("wrapValidCount", 32'(m), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: prefetch buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port freeze  input  1  hazard stall from decode; hold the IF/ID outputs.
REQ-006 SHALL have port branchTaken  input  1  redirect request from execute.
REQ-007 SHALL have port branchAddr  input  32  redirect target, word aligned.
REQ-008 SHALL have port imemReq  output  1  instruction memory read request.
REQ-009 SHALL have port imemAddr  output  32  instruction memory read address.
REQ-010 SHALL have port imemAck  input  1  read data valid, one-cycle pulse.
REQ-011 SHALL have port imemData  input  32  read data, sampled only when imemAck=1.
REQ-012 SHALL have port PC  output  32  fetched address + 4, registered.
REQ-013 SHALL have port instruction  output  32  fetched instruction, registered.
REQ-014 SHALL have port valid  output  1  PC and instruction are meaningful.

Function
REQ-015 SHALL keep fetchPC, the next address to request: RESET_PC at reset, +4 on each accepted response, branchAddr on redirect; 32-bit wrap from 32'hFFFF_FFFC to 0.
REQ-016 SHALL run a request FSM with states IDLE, WAIT, DROP.
REQ-017 IDLE -> WAIT when occupancy + 1 <= DEPTH, no redirect this cycle: assert imemReq, imemAddr=fetchPC.
REQ-018 In WAIT and DROP SHALL hold imemReq=1 and imemAddr constant until imemAck; at most one outstanding request.
REQ-019 WAIT with imemAck: push {imemAddr+4, imemData} into the buffer, advance fetchPC, go IDLE; issuing again requires one IDLE cycle.
REQ-020 Redirect in WAIT without imemAck -> DROP; the response is discarded, then IDLE.
REQ-021 Redirect in the same cycle as imemAck: data discarded, state IDLE, fetchPC=branchAddr.
REQ-022 Redirect in DROP: fetchPC=branchAddr and state stays DROP.
REQ-023 Buffer SHALL be a DEPTH-entry FIFO with simultaneous push and pop allowed in one cycle; no push is ever issued while full (REQ-017 guarantees it).
REQ-024 Redirect SHALL empty the buffer in the same cycle, overriding any push or pop.
REQ-025 Output register, redirect: valid=0, PC=0, instruction=0 next cycle (priority over freeze).
REQ-026 Output register, freeze=1 and no redirect: PC, instruction and valid held; no pop.
REQ-027 Output register, otherwise: if the buffer is non-empty, pop the head into PC/instruction with valid=1; else valid=0 and instruction=0, with PC held.
REQ-028 Fetch-to-valid latency SHALL be 1 cycle after imemAck when the buffer is empty and freeze=0.
REQ-029 An entry pushed and the buffer read in the same cycle SHALL NOT bypass: an empty buffer yields valid=0 that cycle.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, buffer empty, fetchPC=RESET_PC, imemReq=0, imemAddr=RESET_PC, valid=0, PC=0, instruction=0.
REQ-031 Reset mid-request SHALL abandon the request; an imemAck arriving after reset deassertion while IDLE SHALL be ignored.
REQ-032 First request SHALL be issued on the first rising edge with rst=1.

Verification
REQ-033 Zero-wait memory returns the word index, freeze=0 -> valid stream with PC=4,8,12,... and instruction=0,1,2,... in order.
REQ-034 freeze=1 for 5 cycles with memory active -> outputs held; buffer fills to DEPTH and imemReq stays 0; release gives the next in-order instruction with no loss or duplication.
REQ-035 branchTaken with branchAddr=32'h100 while in WAIT, ack 3 cycles later -> stale data dropped; next valid instruction has PC=32'h104.
REQ-036 branchTaken coincident with imemAck -> that word is never presented; first valid after redirect comes from branchAddr.
REQ-037 Assert rst=0 between clock edges during WAIT -> outputs take reset values immediately; after release, imemAddr=RESET_PC.
REQ-038 RESET_PC=32'hFFFF_FFF8, sequential fetch -> imemAddr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
